// File: rtl/instr_mem_pkg.sv
// rtl/instr_mem_pkg.sv - shared types and helpers for the loadable instruction memory
// Contents:
//   NOOP_WORD_DEFAULT : fill/default instruction word (Thumb NOP)
//   state_t           : controller state {INIT, READY}
//   flat_index()      : bank/word to flat RAM index
package instr_mem_pkg;

  localparam logic [15:0] NOOP_WORD_DEFAULT = 16'hBF00;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  // Banks are laid out back to back in one flat RAM.
  function automatic int unsigned flat_index(input int unsigned prog,
                                             input int unsigned addr,
                                             input int unsigned depth);
    return prog * depth + addr;
  endfunction

endpackage

// File: rtl/instr_mem_loadable_if.sv
// rtl/instr_mem_loadable_if.sv - fetch and loader bus of the loadable instruction memory
// Signals:
//   fetch  : prog_sel, fetch_req, fetch_addr, stall -> instr, instr_valid, addr_err
//   loader : ld_en, ld_prog, ld_addr, ld_data -> ld_ready
//   status : busy
//   parity_err exists only when INSTR_MEM_PARITY_EN is defined.
// Modports: master = pipeline/loader side, slave = memory side.
interface instr_mem_loadable_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int PSEL_W = 2
);

  logic [PSEL_W-1:0] prog_sel;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              stall;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              addr_err;
`ifdef INSTR_MEM_PARITY_EN
  logic              parity_err;
`endif
  logic              ld_en;
  logic [PSEL_W-1:0] ld_prog;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              busy;

  modport master (
`ifdef INSTR_MEM_PARITY_EN
    input  parity_err,
`endif
    output prog_sel, fetch_req, fetch_addr, stall,
    output ld_en, ld_prog, ld_addr, ld_data,
    input  instr, instr_valid, addr_err, ld_ready, busy
  );

  modport slave (
`ifdef INSTR_MEM_PARITY_EN
    output parity_err,
`endif
    input  prog_sel, fetch_req, fetch_addr, stall,
    input  ld_en, ld_prog, ld_addr, ld_data,
    output instr, instr_valid, addr_err, ld_ready, busy
  );

endinterface

// File: rtl/instr_mem_bank_ram.sv
// rtl/instr_mem_bank_ram.sv - single write port, single read port synchronous RAM
// Ports:
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read request; rdata updates one cycle later, holds when re=0
// A same-address read and write in one cycle returns the old word.
module instr_mem_bank_ram #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 9,
  parameter int WORDS  = 512
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [WORDS];

  // Both ports share one block so the read samples the pre-write contents.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_mem_loadable.sv
// rtl/instr_mem_loadable.sv - run-time loadable multi-bank instruction memory for fetch
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : instr_mem_loadable_if.slave (fetch, loader, busy)
// After reset every word is swept to NOOP_WORD (busy=1), then loads and fetches
// are accepted. Fetch data appears one cycle after the request; stall holds outputs.
// Optional: INSTR_MEM_PARITY_EN adds a stored even-parity bit and bus.parity_err.
module instr_mem_loadable
  import instr_mem_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 128,
  parameter int NUM_PROG = 4,
  parameter logic [DATA_W-1:0] NOOP_WORD = DATA_W'(NOOP_WORD_DEFAULT)
) (
  input logic clk,
  input logic rst,
  instr_mem_loadable_if.slave bus
);

  localparam int PSEL_W = (NUM_PROG > 1) ? $clog2(NUM_PROG) : 1;
  localparam int TOTAL  = NUM_PROG * DEPTH;
  localparam int IDX_W  = (TOTAL > 1) ? $clog2(TOTAL) : 1;
`ifdef INSTR_MEM_PARITY_EN
  localparam int MEM_W  = DATA_W + 1;
`else
  localparam int MEM_W  = DATA_W;
`endif
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [PSEL_W:0] NPROG_L = (PSEL_W + 1)'(NUM_PROG);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] cnt;
  logic             cnt_last;
  logic             fetch_oor, ld_oor, fetch_go;
  logic [IDX_W-1:0] fetch_idx, ld_idx;
  logic             we;
  logic [IDX_W-1:0] waddr;
  logic [DATA_W-1:0] wdata_raw;
  logic [MEM_W-1:0] wdata, rd_word;
  logic             valid_q, err_q, noop_q;

  assign cnt_last  = (cnt == IDX_W'(TOTAL - 1));
  assign fetch_oor = ({1'b0, bus.fetch_addr} >= DEPTH_L) || ({1'b0, bus.prog_sel} >= NPROG_L);
  assign ld_oor    = ({1'b0, bus.ld_addr} >= DEPTH_L) || ({1'b0, bus.ld_prog} >= NPROG_L);
  assign fetch_idx = IDX_W'(flat_index(32'(bus.prog_sel), 32'(bus.fetch_addr), DEPTH));
  assign ld_idx    = IDX_W'(flat_index(32'(bus.ld_prog), 32'(bus.ld_addr), DEPTH));
  assign fetch_go  = (state == READY) && !bus.stall && bus.fetch_req;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  // Next state: one pass over every word, then READY until the next reset
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (cnt_last) state_nxt = READY;
      READY:   state_nxt = READY;
      default: state_nxt = INIT;
    endcase
  end

  // Outputs: the write port belongs to the sweep in INIT and to the loader in READY
  always_comb begin
    bus.busy     = 1'b1;
    bus.ld_ready = 1'b0;
    we           = 1'b0;
    waddr        = cnt;
    wdata_raw    = NOOP_WORD;
    case (state)
      INIT: we = 1'b1;
      READY: begin
        bus.busy     = 1'b0;
        bus.ld_ready = 1'b1;
        we           = bus.ld_en && !ld_oor;
        waddr        = ld_idx;
        wdata_raw    = bus.ld_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (state == INIT) cnt <= cnt + 1'b1;
  end

`ifdef INSTR_MEM_PARITY_EN
  assign wdata = {^wdata_raw, wdata_raw};
`else
  assign wdata = wdata_raw;
`endif

  instr_mem_bank_ram #(
    .WIDTH  (MEM_W),
    .ADDR_W (IDX_W),
    .WORDS  (TOTAL)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (fetch_go && !fetch_oor),
    .raddr (fetch_idx),
    .rdata (rd_word)
  );

  // The RAM output register already holds across stalls and idle cycles;
  // noop_q remembers whether the last accepted fetch should show NOOP instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      noop_q  <= 1'b1;
    end else if (state == READY && !bus.stall) begin
      valid_q <= bus.fetch_req;
      err_q   <= bus.fetch_req && fetch_oor;
      if (bus.fetch_req) noop_q <= fetch_oor;
    end
  end

  assign bus.instr       = noop_q ? NOOP_WORD : rd_word[DATA_W-1:0];
  assign bus.instr_valid = valid_q;
  assign bus.addr_err    = err_q;
`ifdef INSTR_MEM_PARITY_EN
  assign bus.parity_err  = !noop_q && (^rd_word);
`endif

endmodule

// File: tb/tb_instr_mem_loadable.sv
// tb/tb_instr_mem_loadable.sv - randomized scoreboard bench for instr_mem_loadable
module tb_instr_mem_loadable;

  localparam int DEPTH    = 128;
  localparam int NUM_PROG = 4;
  localparam logic [15:0] NOOP = 16'hBF00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_mem_loadable_if #(.DATA_W(16), .ADDR_W(16), .PSEL_W(2)) bus ();

  instr_mem_loadable #(
    .DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .NUM_PROG(NUM_PROG), .NOOP_WORD(NOOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] instr;
    logic        valid;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model_mem [NUM_PROG][DEPTH];
  logic [15:0] m_instr;
  logic        m_valid, m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one expected output state per driven READY cycle
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("instr", 32'(bus.instr), 32'(e.instr));
        check("instr_valid", 32'(bus.instr_valid), 32'(e.valid));
        check("addr_err", 32'(bus.addr_err), 32'(e.err));
`ifdef INSTR_MEM_PARITY_EN
        check("parity_err", 32'(bus.parity_err), 32'(0));
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic rand_init_inputs();
    bus.ld_en      = 1'($urandom_range(0, 1));
    bus.ld_prog    = 2'($urandom_range(0, 3));
    bus.ld_addr    = 16'($urandom_range(0, DEPTH - 1));
    bus.ld_data    = 16'($urandom);
    bus.fetch_req  = 1'($urandom_range(0, 1));
    bus.prog_sel   = 2'($urandom_range(0, 3));
    bus.fetch_addr = 16'($urandom_range(0, DEPTH - 1));
    bus.stall      = 1'b0;
  endtask

  // Runs the sweep with junk loads/fetches; returns cycles spent busy
  task automatic run_sweep(input int limit, output int n);
    n = 0;
    while (bus.busy && n < limit) begin
      @(posedge clk);
      #1;
      n++;
      check("init_valid", 32'(bus.instr_valid), 32'(0));
      rand_init_inputs();
    end
  endtask

  task automatic check_reset_state();
    check("rst_instr", 32'(bus.instr), 32'(NOOP));
    check("rst_valid", 32'(bus.instr_valid), 32'(0));
    check("rst_err", 32'(bus.addr_err), 32'(0));
    check("rst_ld_ready", 32'(bus.ld_ready), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(1));
  endtask

  // Drive one READY cycle and push the result expected after the next edge
  task automatic step(input logic fr, input logic [1:0] ps, input logic [15:0] fa,
                      input logic st, input logic le, input logic [1:0] lp,
                      input logic [15:0] la, input logic [15:0] ld);
    exp_t e;
    @(negedge clk);
    bus.fetch_req  = fr;
    bus.prog_sel   = ps;
    bus.fetch_addr = fa;
    bus.stall      = st;
    bus.ld_en      = le;
    bus.ld_prog    = lp;
    bus.ld_addr    = la;
    bus.ld_data    = ld;
    if (!st) begin
      if (fr) begin
        m_valid = 1'b1;
        if (int'(fa) >= DEPTH || int'(ps) >= NUM_PROG) begin
          m_instr = NOOP;
          m_err   = 1'b1;
        end else begin
          m_instr = model_mem[ps][fa[6:0]];
          m_err   = 1'b0;
        end
      end else begin
        m_valid = 1'b0;
        m_err   = 1'b0;
      end
    end
    if (le && int'(la) < DEPTH && int'(lp) < NUM_PROG) model_mem[lp][la[6:0]] = ld;
    e.instr = m_instr;
    e.valid = m_valid;
    e.err   = m_err;
    exp_q.push_back(e);
  endtask

  task automatic fetch(input logic [1:0] ps, input logic [15:0] fa);
    step(1'b1, ps, fa, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0);
  endtask

  initial begin
    int n;
    logic [15:0] fib [12];
    fib = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13,
            16'd21, 16'd34, 16'd55, 16'd89};
    rand_init_inputs();
    bus.ld_en = 1'b0;
    bus.fetch_req = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_state();

    // Sweep interrupted by a reset after 100 cycles
    @(negedge clk);
    rst = 1'b0;
    rand_init_inputs();
    run_sweep(100, n);
    check("partial_sweep_busy", 32'(bus.busy), 32'(1));
    rst = 1'b1;
    #1;
    check_reset_state();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rand_init_inputs();
    run_sweep(2000, n);
    check("sweep_cycles", 32'(n), 32'(NUM_PROG * DEPTH));
    check("ready_ld_ready", 32'(bus.ld_ready), 32'(1));
    check("ready_busy", 32'(bus.busy), 32'(0));
    bus.ld_en = 1'b0;
    bus.fetch_req = 1'b0;

    for (int p = 0; p < NUM_PROG; p++)
      for (int a = 0; a < DEPTH; a++) model_mem[p][a] = NOOP;
    m_instr = NOOP;
    m_valid = 1'b0;
    m_err   = 1'b0;

    // Everything reads NOOP, including bank 2 and words hit by INIT-time loads
    for (int i = 0; i < 16; i++) fetch(2'd2, 16'($urandom_range(0, DEPTH - 1)));
    for (int i = 0; i < 48; i++) fetch(2'($urandom_range(0, 3)), 16'($urandom_range(0, DEPTH - 1)));

    // Fibonacci program in bank 0
    for (int i = 0; i < 12; i++) step(1'b0, 2'd0, 16'd0, 1'b0, 1'b1, 2'd0, 16'(i), fib[i]);
    for (int i = 0; i < 12; i++) fetch(2'd0, 16'(i));

    // Stall hold with a changing address
    fetch(2'd0, 16'd5);
    for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 16'($urandom_range(0, 11)), 1'b1, 1'b0, 2'd0, 16'd0, 16'd0);
    fetch(2'd0, 16'd9);

    // Out of range, then an in-range fetch clears addr_err
    fetch(2'd1, 16'd200);
    fetch(2'd0, 16'd3);

    // Same-cycle load and fetch of one word
    step(1'b1, 2'd1, 16'd7, 1'b0, 1'b1, 2'd1, 16'd7, 16'h1234);
    fetch(2'd1, 16'd7);
    // Out-of-range load is dropped
    step(1'b0, 2'd0, 16'd0, 1'b0, 1'b1, 2'd1, 16'd135, 16'hDEAD);
    fetch(2'd1, 16'd7);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [15:0] fa, la;
      fa = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(DEPTH, 300)) : 16'($urandom_range(0, DEPTH - 1));
      la = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(DEPTH, 300)) : 16'($urandom_range(0, DEPTH - 1));
      step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), fa,
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), la, 16'($urandom));
    end
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0);

    repeat (3) @(posedge clk);
    #2;
    check("drain", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
